// File: rtl/jkb_pkg.sv
// Shared opcode and FSM state encodings for the JK bank controller.
package jkb_pkg;

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_SET    = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_UP     = 3'd5;
  localparam logic [2:0] OP_DOWN   = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/jk_bit_cell.sv
// Single JK flip-flop: 00 hold, 01 clear, 10 set, 11 toggle; async clear on R.
module jk_bit_cell (
  input  logic Clk,
  input  logic R,
  input  logic J,
  input  logic K,
  output logic Q
);

  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        2'b11:   Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Sequences a bank of JK cells from one valid/ready command at a time; single ops take 1 edge, counts N edges.
// cmd_ready only in IDLE; JKB_SAT_EN makes UP/DOWN saturate and report sat.
module jk_bank_ctrl
  import jkb_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic [WIDTH-1:0]  q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sat
);

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [STEP_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]    j_drv, k_drv;
  logic [WIDTH-1:0]    qv, lm, tgl;
`ifdef JKB_SAT_EN
  logic                sat_q, sat_d;
  logic                at_bound;
`endif

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_cell
      jk_bit_cell u_cell (
        .Clk (Clk),
        .R   (R),
        .J   (j_drv[g]),
        .K   (k_drv[g]),
        .Q   (q[g])
      );
    end
  endgenerate

  // Counting down is counting up on the inverted bank: bit i flips when all lower bits carry/borrow.
  always_comb begin
    qv  = (op_q == OP_UP) ? q : ~q;
    lm  = '0;
    tgl = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lm     = WIDTH'((1 << i) - 1);
      tgl[i] = &(qv | ~lm);
    end
`ifdef JKB_SAT_EN
    at_bound = &qv;
    if (at_bound) tgl = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    j_drv   = '0;
    k_drv   = '0;
`ifdef JKB_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          cnt_d  = cmd_steps;
`ifdef JKB_SAT_EN
          sat_d  = 1'b0;
`endif
          if (cmd_op == OP_UP || cmd_op == OP_DOWN) begin
            state_d = (cmd_steps != '0) ? ST_RUN : ST_DONE;
          end else begin
            state_d = ST_APPLY;
          end
        end
      end
      ST_APPLY: begin
        case (op_q)
          OP_LOAD: begin
            j_drv = data_q;
            k_drv = ~data_q;
          end
          OP_CLEAR:  k_drv = '1;
          OP_SET:    j_drv = '1;
          OP_TOGGLE: begin
            j_drv = data_q;
            k_drv = data_q;
          end
          default: ;
        endcase
        state_d = ST_DONE;
      end
      ST_RUN: begin
        j_drv = tgl;
        k_drv = tgl;
        cnt_d = cnt_q - 1'b1;
`ifdef JKB_SAT_EN
        if (at_bound) sat_d = 1'b1;
`endif
        if (cnt_q == STEP_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef JKB_SAT_EN
  always_ff @(posedge Clk or posedge R) begin
    if (R) sat_q <= 1'b0;
    else   sat_q <= sat_d;
  end
  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_APPLY) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign err       = done && (op_q == OP_RSVD);

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl (WIDTH=4); expectations follow JKB_SAT_EN when defined.
module tb_jk_bank_ctrl;
  import jkb_pkg::*;

  localparam int W  = 4;
  localparam int SW = 8;
`ifdef JKB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          R;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [SW-1:0] cmd_steps;
  logic [W-1:0]  q;
  logic          busy, done, err, sat;

  always #5 Clk = ~Clk;

  jk_bank_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
    .Clk       (Clk),
    .R         (R),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_steps (cmd_steps),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sat       (sat)
  );

  typedef struct {
    logic [W-1:0] q;
    logic         err;
    logic         sat;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           n_chk = 0;
  int           n_err = 0;
  logic [W-1:0] mq = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic bit bound_hit(input logic [W-1:0] v, input bit up);
    return SAT_EN && (up ? (v == {W{1'b1}}) : (v == '0));
  endfunction

  function automatic logic [W-1:0] step1(input logic [W-1:0] v, input bit up);
    logic [W-1:0] r;
    r = up ? v + 1'b1 : v - 1'b1;
    return r;
  endfunction

  task automatic model(input logic [2:0] op, input logic [W-1:0] d, input logic [SW-1:0] n,
                       output exp_t e);
    e.err = (op == OP_RSVD);
    e.sat = 1'b0;
    e.lat = 2;
    case (op)
      OP_LOAD:   mq = d;
      OP_CLEAR:  mq = '0;
      OP_SET:    mq = '1;
      OP_TOGGLE: mq = mq ^ d;
      OP_UP, OP_DOWN: begin
        e.lat = (n == 0) ? 1 : int'(n) + 1;
        for (int s = 0; s < int'(n); s++) begin
          if (bound_hit(mq, op == OP_UP)) e.sat = 1'b1;
          else mq = step1(mq, op == OP_UP);
        end
      end
      default: ;
    endcase
    e.q = mq;
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] d, input logic [SW-1:0] n);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(negedge Clk);
      t++;
    end
    if (t == 50) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_steps = n;
    @(posedge Clk);
    #1;
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, ((op == OP_UP || op == OP_DOWN) && n == 0) ? 0 : 1);
    chk("ready_after_accept", cmd_ready, 0);
  endtask

  task automatic wait_done();
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (done !== 1'b1 && lat < 200);
    if (done !== 1'b1) begin
      chk("done_timeout", done, 1);
    end else if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("q", q, e.q);
      chk("err", err, e.err);
      chk("sat", sat, e.sat);
      chk("latency", lat, e.lat);
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] d, input logic [SW-1:0] n,
                        input bit trace);
    exp_t         e;
    logic [W-1:0] pv;
    pv = mq;
    model(op, d, n, e);
    if (trace) e.lat = 1;
    sb.push_back(e);
    send(op, d, n);
    if (trace) begin
      for (int s = 0; s < int'(n); s++) begin
        @(posedge Clk);
        #1;
        if (!bound_hit(pv, op == OP_UP)) pv = step1(pv, op == OP_UP);
        chk("step_q", q, pv);
      end
    end
    wait_done();
    @(negedge Clk);
    chk("done_width", done, 0);
    chk("err_width", err, 0);
    chk("ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1, e2;
    int   dcnt;
    R = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_steps = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_q", q, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat, 0);
    @(negedge Clk);
    R = 1'b0;

    // Abort an UP count mid-run with reset
    send(OP_UP, '0, 8'd10);
    repeat (3) @(posedge Clk);
    #1;
    chk("midrun_q", q, 3);
    #2 R = 1'b1;
    #1;
    chk("abort_q", q, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    @(negedge Clk);
    R = 1'b0;
    dcnt = 0;
    repeat (15) begin
      @(negedge Clk);
      if (done === 1'b1) dcnt++;
    end
    chk("no_done_after_abort", dcnt, 0);
    mq = '0;

    do_cmd(OP_LOAD,   4'hA, 8'd0, 1'b0);
    do_cmd(OP_TOGGLE, 4'h3, 8'd0, 1'b0);
    do_cmd(OP_SET,    4'h0, 8'd0, 1'b0);
    do_cmd(OP_CLEAR,  4'h0, 8'd0, 1'b0);
    do_cmd(OP_LOAD,   4'hE, 8'd0, 1'b0);
    do_cmd(OP_UP,     4'h0, 8'd3, 1'b1);
    do_cmd(OP_LOAD,   4'h5, 8'd0, 1'b0);
    do_cmd(OP_DOWN,   4'h0, 8'd0, 1'b0);
    do_cmd(OP_DOWN,   4'h0, 8'd6, 1'b0);
    do_cmd(OP_HOLD,   4'hF, 8'd0, 1'b0);

    // Reserved op with cmd_valid held: the following LOAD must wait for IDLE
    model(OP_RSVD, 4'hF, 8'd0, e1);
    sb.push_back(e1);
    model(OP_LOAD, 4'h3, 8'd0, e2);
    e2.lat = 3;
    sb.push_back(e2);
    while (cmd_ready !== 1'b1) @(negedge Clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_RSVD;
    cmd_data  = 4'hF;
    cmd_steps = '0;
    @(posedge Clk);
    #1;
    cmd_op   = OP_LOAD;
    cmd_data = 4'h3;
    chk("held_busy", busy, 1);
    wait_done();
    wait_done();
    cmd_valid = 1'b0;
    @(negedge Clk);
    chk("held_done_width", done, 0);
    repeat (3) @(negedge Clk);
    chk("held_no_reaccept", q, 4'h3);

    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
